// File: rtl/rwt_tag_insert_escape_multi_pkg.sv
// Shared definitions for the multi-word tag escape inserter: one-hot FSM encoding
// and tag-index sizing, common with the downstream tag extractor.
package rwt_tag_insert_escape_multi_pkg;

    localparam int TAG_WORDS_MAX = 15;
    localparam int IDX_W         = $clog2(TAG_WORDS_MAX + 1);

    typedef enum logic [4:0] {
        ST_PASS      = 5'b00001,
        ST_ESCAPE    = 5'b00010,
        ST_TAG       = 5'b00100,
        ST_SEND_DATA = 5'b01000,
        ST_STUFF     = 5'b10000
    } tag_state_e;

    // States in which the upstream beat is still waiting behind inserted words.
    function automatic logic is_insert_state(input tag_state_e s);
        return (s == ST_ESCAPE) || (s == ST_TAG);
    endfunction

endpackage

// File: rtl/rwt_tag_insert_escape_multi_if.sv
// Stream bundle for the tag inserter: tagged upstream beats in, flat words out.
interface rwt_tag_insert_escape_multi_if #(
    parameter int DWIDTH    = 64,
    parameter int TAG_WORDS = 1
);
    logic                        s_axi_valid;
    logic                        s_axi_ready;
    logic                        s_axi_escape;
    logic [TAG_WORDS*DWIDTH-1:0] s_axi_tag;
    logic [DWIDTH-1:0]           s_axi_data;
    logic                        s_axi_last;

    logic                        m_axi_valid;
    logic                        m_axi_ready;
    logic [DWIDTH-1:0]           m_axi_data;
    logic                        m_axi_last;

    // Design view: consumes the upstream beat, produces the output stream.
    modport slave (
        input  s_axi_valid, s_axi_escape, s_axi_tag, s_axi_data, s_axi_last, m_axi_ready,
        output s_axi_ready, m_axi_valid, m_axi_data, m_axi_last
    );

    modport master (
        output s_axi_valid, s_axi_escape, s_axi_tag, s_axi_data, s_axi_last, m_axi_ready,
        input  s_axi_ready, m_axi_valid, m_axi_data, m_axi_last
    );
endinterface

// File: rtl/rwt_tag_insert_escape_multi_fifo.sv
// Synchronous output FIFO with a registered read port (util_axis_fifo style,
// M_AXIS_REGISTERED=1): ring buffer of 2**ADDRESS_WIDTH entries plus one output register.
module rwt_tag_insert_escape_multi_fifo #(
    parameter int DATA_WIDTH    = 65,
    parameter int ADDRESS_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o
);
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] FULL_CNT = (ADDRESS_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
    logic [ADDRESS_WIDTH-1:0] wr_ptr_q;
    logic [ADDRESS_WIDTH-1:0] rd_ptr_q;
    logic [ADDRESS_WIDTH:0]   count_q;
    logic                     m_valid_q;
    logic [DATA_WIDTH-1:0]    m_data_q;

    logic wr_en;
    logic rd_en;

    assign s_ready_o = (count_q != FULL_CNT);
    assign wr_en     = s_valid_i & s_ready_o;
    assign rd_en     = (count_q != '0) & (~m_valid_q | m_ready_i);
    assign m_valid_o = m_valid_q;
    assign m_data_o  = m_data_q;

    // NOTE: storage has no reset; the count and pointers alone decide what is valid,
    // so flushing them on reset is enough and keeps the array a plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= s_data_i;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + ADDRESS_WIDTH'(1);
            end
            if (rd_en) begin
                rd_ptr_q  <= rd_ptr_q + ADDRESS_WIDTH'(1);
                m_data_q  <= mem_q[rd_ptr_q];
                m_valid_q <= 1'b1;
            end else if (m_ready_i) begin
                m_valid_q <= 1'b0;
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + (ADDRESS_WIDTH + 1)'(1);
                2'b01:   count_q <= count_q - (ADDRESS_WIDTH + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rwt_tag_insert_escape_multi.sv
// Multi-word tag escape inserter: escape-flagged beats become escape word, TAG_WORDS tag
// words, then the data; literal data equal to the escape word is optionally doubled.
module rwt_tag_insert_escape_multi
    import rwt_tag_insert_escape_multi_pkg::*;
#(
    parameter int DWIDTH    = 64,
    parameter int TAG_WORDS = 1,
    parameter int FIFO_AW   = 2,
    parameter int CNT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         aresetn,
    input  logic [DWIDTH-1:0]            tag_escape,
    input  logic                         cfg_stuff_en,
    rwt_tag_insert_escape_multi_if.slave bus,
    output logic [CNT_WIDTH-1:0]         stat_escapes,
    output logic [CNT_WIDTH-1:0]         stat_stuffed,
    output logic                         tag_err
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAG_WORDS - 1);

    tag_state_e           state_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 run_q;
    logic [CNT_WIDTH-1:0] esc_cnt_q;
    logic [CNT_WIDTH-1:0] stuff_cnt_q;
    logic                 tag_err_q;

    logic              fifo_s_ready;
    logic              fifo_ready;
    logic              stuff_hit;
    logic              tag_collide;
    logic              wr_en;
    logic              wr_last;
    logic              s_ready;
    logic [DWIDTH-1:0] wr_data;
    logic [DWIDTH-1:0] tag_word;
    logic [DWIDTH:0]   fifo_m_data;

    // run_q holds off the first write for one cycle after reset release.
    assign fifo_ready  = fifo_s_ready & run_q;
    assign stuff_hit   = cfg_stuff_en & ~bus.s_axi_escape & (bus.s_axi_data == tag_escape);
    assign tag_collide = (bus.s_axi_tag[DWIDTH-1:0] == tag_escape);

    always_comb begin
        tag_word = '0;
        for (int i = 0; i < TAG_WORDS; i++) begin
            if (idx_q == i[IDX_W-1:0]) begin
                tag_word = bus.s_axi_tag[i*DWIDTH +: DWIDTH];
            end
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves one
    // unassigned; that is what keeps the word mux free of inferred latches.
    always_comb begin
        wr_en   = bus.s_axi_valid & fifo_ready;
        wr_data = bus.s_axi_data;
        wr_last = bus.s_axi_last;
        s_ready = 1'b0;
        case (state_q)
            ST_PASS: begin
                if (bus.s_axi_escape || stuff_hit) begin
                    wr_data = tag_escape;
                    wr_last = 1'b0;
                end else begin
                    s_ready = fifo_ready;
                end
            end
            ST_ESCAPE: begin
                wr_data = tag_escape;
                wr_last = 1'b0;
            end
            ST_TAG: begin
                wr_data = tag_word;
                wr_last = 1'b0;
            end
            ST_SEND_DATA, ST_STUFF: begin
                s_ready = fifo_ready;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_PASS;
            idx_q       <= '0;
            run_q       <= 1'b0;
            esc_cnt_q   <= '0;
            stuff_cnt_q <= '0;
            tag_err_q   <= 1'b0;
        end else begin
            run_q     <= 1'b1;
            tag_err_q <= 1'b0;
            case (state_q)
                ST_PASS: begin
                    if (bus.s_axi_valid && bus.s_axi_escape) begin
                        // The escape decision is taken even when the FIFO is full.
                        tag_err_q <= tag_collide;
                        idx_q     <= '0;
                        state_q   <= fifo_ready ? ST_TAG : ST_ESCAPE;
                    end else if (wr_en && stuff_hit) begin
                        state_q <= ST_STUFF;
                    end
                end
                ST_ESCAPE: begin
                    if (wr_en) begin
                        idx_q   <= '0;
                        state_q <= ST_TAG;
                    end
                end
                ST_TAG: begin
                    if (wr_en) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_SEND_DATA;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_SEND_DATA: begin
                    if (wr_en) begin
                        esc_cnt_q <= esc_cnt_q + CNT_WIDTH'(1);
                        state_q   <= ST_PASS;
                    end
                end
                ST_STUFF: begin
                    if (wr_en) begin
                        stuff_cnt_q <= stuff_cnt_q + CNT_WIDTH'(1);
                        state_q     <= ST_PASS;
                    end
                end
                default: begin
                    state_q <= ST_PASS;
                end
            endcase
        end
    end

    rwt_tag_insert_escape_multi_fifo #(
        .DATA_WIDTH   (DWIDTH + 1),
        .ADDRESS_WIDTH(FIFO_AW)
    ) u_fifo (
        .clk      (clk),
        .aresetn  (aresetn),
        .s_valid_i(wr_en),
        .s_ready_o(fifo_s_ready),
        .s_data_i ({wr_last, wr_data}),
        .m_valid_o(bus.m_axi_valid),
        .m_ready_i(bus.m_axi_ready),
        .m_data_o (fifo_m_data)
    );

    // Upstream never sees ready while its beat is parked behind inserted words.
    assign bus.s_axi_ready = s_ready & ~is_insert_state(state_q);
    assign bus.m_axi_data  = fifo_m_data[DWIDTH-1:0];
    assign bus.m_axi_last  = fifo_m_data[DWIDTH];
    assign stat_escapes    = esc_cnt_q;
    assign stat_stuffed    = stuff_cnt_q;
    assign tag_err         = tag_err_q;

endmodule

// File: tb/tb_rwt_tag_insert_escape_multi.sv
// Directed bench for the multi-word tag escape inserter (TAG_WORDS=2).
module tb_rwt_tag_insert_escape_multi;

    localparam int DW          = 64;
    localparam int TW          = 2;
    localparam int CW          = 32;
    localparam int BEAT_BUDGET = 300;
    localparam int WORD_BUDGET = 3000;

    typedef logic [DW:0] word_t;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic [DW-1:0] tag_escape;
    logic          cfg_stuff_en;
    logic [CW-1:0] stat_escapes;
    logic [CW-1:0] stat_stuffed;
    logic          tag_err;

    rwt_tag_insert_escape_multi_if #(.DWIDTH(DW), .TAG_WORDS(TW)) bus ();

    rwt_tag_insert_escape_multi #(
        .DWIDTH   (DW),
        .TAG_WORDS(TW),
        .FIFO_AW  (2),
        .CNT_WIDTH(CW)
    ) dut (
        .clk         (clk),
        .aresetn     (aresetn),
        .tag_escape  (tag_escape),
        .cfg_stuff_en(cfg_stuff_en),
        .bus         (bus),
        .stat_escapes(stat_escapes),
        .stat_stuffed(stat_stuffed),
        .tag_err     (tag_err)
    );

    always #5 clk = ~clk;

    int    passed = 0;
    int    total = 0;
    word_t act_q[$];
    word_t exp_q[$];
    int    tag_err_cnt = 0;
    bit    bp_mode = 1'b0;

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (aresetn && bus.m_axi_valid && bus.m_axi_ready) begin
            act_q.push_back({bus.m_axi_last, bus.m_axi_data});
        end
        if (tag_err) begin
            tag_err_cnt++;
        end
    end

    // Downstream ready: constant 1, or high one cycle in three under backpressure.
    initial begin
        int ph = 0;
        bus.m_axi_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                bus.m_axi_ready = (ph == 0);
                ph = (ph + 1) % 3;
            end else begin
                bus.m_axi_ready = 1'b1;
            end
        end
    end

    task automatic model_beat(input logic esc, input logic [TW*DW-1:0] tag,
                              input logic [DW-1:0] data, input logic last, input logic stuff);
        if (esc) begin
            exp_q.push_back({1'b0, tag_escape});
            for (int i = 0; i < TW; i++) exp_q.push_back({1'b0, tag[i*DW +: DW]});
            exp_q.push_back({last, data});
        end else if (stuff && (data == tag_escape)) begin
            exp_q.push_back({1'b0, tag_escape});
            exp_q.push_back({last, data});
        end else begin
            exp_q.push_back({last, data});
        end
    endtask

    // Presents one beat; waited = cycles with ready low before acceptance.
    task automatic send_beat(input logic esc, input logic [TW*DW-1:0] tag,
                             input logic [DW-1:0] data, input logic last, output int waited);
        bus.s_axi_valid  = 1'b1;
        bus.s_axi_escape = esc;
        bus.s_axi_tag    = tag;
        bus.s_axi_data   = data;
        bus.s_axi_last   = last;
        waited = 0;
        forever begin
            @(negedge clk);
            if (bus.s_axi_ready) break;
            waited++;
            if (waited >= BEAT_BUDGET) break;
        end
        @(posedge clk);
        #1;
        bus.s_axi_valid  = 1'b0;
        bus.s_axi_escape = 1'b0;
    endtask

    task automatic wait_words(input int ab, input int n);
        int cyc = 0;
        while ((act_q.size() < ab + n) && (cyc < WORD_BUDGET)) begin
            @(negedge clk);
            cyc++;
        end
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    function automatic int word_errs(input int ab, input int eb, input int n);
        int e = 0;
        for (int i = 0; i < n; i++) begin
            if ((ab + i >= act_q.size()) || (act_q[ab + i] !== exp_q[eb + i])) e++;
        end
        return e;
    endfunction

    task automatic test_reset();
        bus.s_axi_valid  = 1'b0;
        bus.s_axi_escape = 1'b0;
        bus.s_axi_tag    = '0;
        bus.s_axi_data   = '0;
        bus.s_axi_last   = 1'b0;
        tag_escape       = 64'hFFFF_0000_DEAD_BEEF;
        cfg_stuff_en     = 1'b0;
        aresetn          = 1'b0;
        #12;
        bus.s_axi_valid = 1'b1;
        #1;
        total++; if (bus.m_axi_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", bus.m_axi_valid); else passed++;
        total++; if (bus.s_axi_ready !== 1'b0) $display("FAIL reset_s_ready: got %b want 0", bus.s_axi_ready); else passed++;
        total++; if (stat_escapes !== '0) $display("FAIL reset_stat_escapes: got %0d want 0", stat_escapes); else passed++;
        total++; if (stat_stuffed !== '0) $display("FAIL reset_stat_stuffed: got %0d want 0", stat_stuffed); else passed++;
        total++; if (tag_err !== 1'b0) $display("FAIL reset_tag_err: got %b want 0", tag_err); else passed++;
        bus.s_axi_valid = 1'b0;
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_plain();
        int ab = act_q.size();
        int eb = exp_q.size();
        int w;
        int maxw = 0;
        cfg_stuff_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send_beat(1'b0, '0, DW'(i), (i == 4), w);
            model_beat(1'b0, '0, DW'(i), (i == 4), 1'b0);
            if (w > maxw) maxw = w;
        end
        wait_words(ab, 4);
        total++; if (act_q.size() - ab != 4) $display("FAIL plain_count: got %0d want 4", act_q.size() - ab); else passed++;
        total++; if (word_errs(ab, eb, 4) != 0) $display("FAIL plain_words: %0d bad words, want 0", word_errs(ab, eb, 4)); else passed++;
        total++; if (maxw != 0) $display("FAIL plain_throughput: stall %0d want 0", maxw); else passed++;
        total++; if (stat_escapes !== 32'd0) $display("FAIL plain_stat_escapes: got %0d want 0", stat_escapes); else passed++;
        total++; if (stat_stuffed !== 32'd0) $display("FAIL plain_stat_stuffed: got %0d want 0", stat_stuffed); else passed++;
    endtask

    task automatic test_escape();
        int ab = act_q.size();
        int eb = exp_q.size();
        int te = tag_err_cnt;
        int w;
        logic [TW*DW-1:0] tag = {64'hB, 64'hA};
        send_beat(1'b1, tag, 64'h55, 1'b1, w);
        exp_q.push_back({1'b0, 64'hFFFF_0000_DEAD_BEEF});
        exp_q.push_back({1'b0, 64'hA});
        exp_q.push_back({1'b0, 64'hB});
        exp_q.push_back({1'b1, 64'h55});
        wait_words(ab, 4);
        total++; if (act_q.size() - ab != 4) $display("FAIL escape_count: got %0d want 4", act_q.size() - ab); else passed++;
        total++; if (word_errs(ab, eb, 4) != 0) $display("FAIL escape_words: %0d bad words, want 0", word_errs(ab, eb, 4)); else passed++;
        total++; if (w != 3) $display("FAIL escape_cost: stall %0d want 3", w); else passed++;
        total++; if (stat_escapes !== 32'd1) $display("FAIL escape_stat: got %0d want 1", stat_escapes); else passed++;
        total++; if (tag_err_cnt != te) $display("FAIL escape_no_tag_err: got %0d pulses want 0", tag_err_cnt - te); else passed++;
    endtask

    task automatic test_stuffing();
        int ab = act_q.size();
        int eb = exp_q.size();
        int w;
        cfg_stuff_en = 1'b1;
        send_beat(1'b0, '0, tag_escape, 1'b1, w);
        exp_q.push_back({1'b0, 64'hFFFF_0000_DEAD_BEEF});
        exp_q.push_back({1'b1, 64'hFFFF_0000_DEAD_BEEF});
        wait_words(ab, 2);
        total++; if (act_q.size() - ab != 2) $display("FAIL stuff_count: got %0d want 2", act_q.size() - ab); else passed++;
        total++; if (word_errs(ab, eb, 2) != 0) $display("FAIL stuff_words: %0d bad words, want 0", word_errs(ab, eb, 2)); else passed++;
        total++; if (w != 1) $display("FAIL stuff_cost: stall %0d want 1", w); else passed++;
        total++; if (stat_stuffed !== 32'd1) $display("FAIL stuff_stat: got %0d want 1", stat_stuffed); else passed++;
        ab = act_q.size();
        eb = exp_q.size();
        cfg_stuff_en = 1'b0;
        send_beat(1'b0, '0, tag_escape, 1'b1, w);
        exp_q.push_back({1'b1, 64'hFFFF_0000_DEAD_BEEF});
        wait_words(ab, 1);
        total++; if (act_q.size() - ab != 1) $display("FAIL nostuff_count: got %0d want 1", act_q.size() - ab); else passed++;
        total++; if (word_errs(ab, eb, 1) != 0) $display("FAIL nostuff_words: %0d bad words, want 0", word_errs(ab, eb, 1)); else passed++;
        total++; if (stat_stuffed !== 32'd1) $display("FAIL nostuff_stat: got %0d want 1", stat_stuffed); else passed++;
    endtask

    task automatic test_backpressure();
        int ab = act_q.size();
        int eb = exp_q.size();
        int w, r, n;
        int viol = 0;
        int tmo = 0;
        int n_esc = 0;
        int n_stuff = 0;
        logic [CW-1:0] esc0 = stat_escapes;
        logic [CW-1:0] stf0 = stat_stuffed;
        logic esc, last;
        logic [DW-1:0] data;
        logic [TW*DW-1:0] tag;
        cfg_stuff_en = 1'b1;
        bp_mode = 1'b1;
        for (int b = 0; b < 200; b++) begin
            r    = $urandom_range(0, 99);
            esc  = (r < 25);
            data = (r >= 25 && r < 35) ? tag_escape : {$urandom(), $urandom()};
            tag  = {$urandom(), $urandom(), $urandom(), $urandom()};
            last = ($urandom_range(0, 3) == 0);
            send_beat(esc, tag, data, last, w);
            model_beat(esc, tag, data, last, 1'b1);
            if (w >= BEAT_BUDGET) tmo++;
            if (esc) begin
                n_esc++;
                if (w < 1 + TW) viol++;
            end else if (data == tag_escape) begin
                n_stuff++;
                if (w < 1) viol++;
            end
        end
        n = exp_q.size() - eb;
        wait_words(ab, n);
        bp_mode = 1'b0;
        total++; if (act_q.size() - ab != n) $display("FAIL bp_count: got %0d want %0d", act_q.size() - ab, n); else passed++;
        total++; if (word_errs(ab, eb, n) != 0) $display("FAIL bp_words: %0d bad words, want 0", word_errs(ab, eb, n)); else passed++;
        total++; if (viol != 0) $display("FAIL bp_ready_during_insert: got %0d want 0", viol); else passed++;
        total++; if (tmo != 0) $display("FAIL bp_timeout: got %0d want 0", tmo); else passed++;
        total++; if (stat_escapes - esc0 != CW'(n_esc)) $display("FAIL bp_stat_escapes: got %0d want %0d", stat_escapes - esc0, n_esc); else passed++;
        total++; if (stat_stuffed - stf0 != CW'(n_stuff)) $display("FAIL bp_stat_stuffed: got %0d want %0d", stat_stuffed - stf0, n_stuff); else passed++;
    endtask

    task automatic test_tag_collision();
        int ab = act_q.size();
        int eb = exp_q.size();
        int te = tag_err_cnt;
        int w;
        logic [TW*DW-1:0] tag = {64'h1234, 64'hFFFF_0000_DEAD_BEEF};
        cfg_stuff_en = 1'b0;
        send_beat(1'b1, tag, 64'h99, 1'b1, w);
        exp_q.push_back({1'b0, 64'hFFFF_0000_DEAD_BEEF});
        exp_q.push_back({1'b0, 64'hFFFF_0000_DEAD_BEEF});
        exp_q.push_back({1'b0, 64'h1234});
        exp_q.push_back({1'b1, 64'h99});
        wait_words(ab, 4);
        total++; if (tag_err_cnt - te != 1) $display("FAIL collision_tag_err: got %0d pulses want 1", tag_err_cnt - te); else passed++;
        total++; if (act_q.size() - ab != 4) $display("FAIL collision_count: got %0d want 4", act_q.size() - ab); else passed++;
        total++; if (word_errs(ab, eb, 4) != 0) $display("FAIL collision_words: %0d bad words, want 0", word_errs(ab, eb, 4)); else passed++;
    endtask

    task automatic test_reset_mid();
        int ab, eb, w;
        bus.s_axi_valid  = 1'b1;
        bus.s_axi_escape = 1'b1;
        bus.s_axi_tag    = {64'hBB, 64'hAA};
        bus.s_axi_data   = 64'h66;
        bus.s_axi_last   = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        aresetn = 1'b0;
        #1;
        total++; if (bus.m_axi_valid !== 1'b0) $display("FAIL midreset_m_valid: got %b want 0", bus.m_axi_valid); else passed++;
        total++; if (bus.s_axi_ready !== 1'b0) $display("FAIL midreset_s_ready: got %b want 0", bus.s_axi_ready); else passed++;
        total++; if (stat_escapes !== 32'd0) $display("FAIL midreset_stat_escapes: got %0d want 0", stat_escapes); else passed++;
        total++; if (stat_stuffed !== 32'd0) $display("FAIL midreset_stat_stuffed: got %0d want 0", stat_stuffed); else passed++;
        bus.s_axi_valid  = 1'b0;
        bus.s_axi_escape = 1'b0;
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ab = act_q.size();
        eb = exp_q.size();
        send_beat(1'b1, {64'h22, 64'h11}, 64'h77, 1'b1, w);
        exp_q.push_back({1'b0, 64'hFFFF_0000_DEAD_BEEF});
        exp_q.push_back({1'b0, 64'h11});
        exp_q.push_back({1'b0, 64'h22});
        exp_q.push_back({1'b1, 64'h77});
        wait_words(ab, 4);
        total++; if (act_q.size() - ab != 4) $display("FAIL postreset_count: got %0d want 4", act_q.size() - ab); else passed++;
        total++; if (word_errs(ab, eb, 4) != 0) $display("FAIL postreset_words: %0d bad words, want 0", word_errs(ab, eb, 4)); else passed++;
        total++; if (stat_escapes !== 32'd1) $display("FAIL postreset_stat: got %0d want 1", stat_escapes); else passed++;
    endtask

    initial begin
        test_reset();
        test_plain();
        test_escape();
        test_stuffing();
        test_backpressure();
        test_tag_collision();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", passed, total);
        $fatal(1);
    end

endmodule
